// File: rtl/rsa_job_arbiter_if.sv
// Bundle of the two requester channels, the shared response channel and the core-side wires of rsa_job_arbiter.
// slave = arbiter view; master = environment view (requesters, response sink, core).
interface rsa_job_arbiter_if #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
);
  logic              i_req0_valid;
  logic              o_req0_ready;
  logic [DATA_W-1:0] i_req0_a;
  logic [DATA_W-1:0] i_req0_d;
  logic [DATA_W-1:0] i_req0_n;

  logic              i_req1_valid;
  logic              o_req1_ready;
  logic [DATA_W-1:0] i_req1_a;
  logic [DATA_W-1:0] i_req1_d;
  logic [DATA_W-1:0] i_req1_n;

  logic              o_rsp_valid;
  logic              i_rsp_ready;
  logic              o_rsp_id;
  logic [DATA_W-1:0] o_rsp_data;

  logic              o_core_start;
  logic [DATA_W-1:0] o_core_a;
  logic [DATA_W-1:0] o_core_d;
  logic [DATA_W-1:0] o_core_n;
  logic [DATA_W-1:0] i_core_result;
  logic              i_core_finished;

  logic              o_busy;
  logic [CNT_W-1:0]  o_jobs_done;
  logic              o_spurious;

  modport slave (
    input  i_req0_valid, i_req0_a, i_req0_d, i_req0_n,
    output o_req0_ready,
    input  i_req1_valid, i_req1_a, i_req1_d, i_req1_n,
    output o_req1_ready,
    output o_rsp_valid, o_rsp_id, o_rsp_data,
    input  i_rsp_ready,
    output o_core_start, o_core_a, o_core_d, o_core_n,
    input  i_core_result, i_core_finished,
    output o_busy, o_jobs_done, o_spurious
  );

  modport master (
    output i_req0_valid, i_req0_a, i_req0_d, i_req0_n,
    input  o_req0_ready,
    output i_req1_valid, i_req1_a, i_req1_d, i_req1_n,
    input  o_req1_ready,
    input  o_rsp_valid, o_rsp_id, o_rsp_data,
    output i_rsp_ready,
    input  o_core_start, o_core_a, o_core_d, o_core_n,
    output i_core_result, i_core_finished,
    input  o_busy, o_jobs_done, o_spurious
  );
endinterface

// File: rtl/rsa_job_arbiter.sv
// Round-robin scheduler sharing one Rsa256Core between two requesters: grant->start 1 cycle, finish->rsp_valid 1 cycle.
// Backpressure: a stalled response holds id/data and blocks all new grants until i_rsp_ready.
module rsa_job_arbiter #(
  parameter int DATA_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  rsa_job_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] d_q, d_d;
  logic [DATA_W-1:0] n_q, n_d;
  logic [DATA_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]  jobs_q, jobs_d;
  logic              spurious_q, spurious_d;

  logic any_valid;
  logic grant;
  logic grant_fire;

  // Tie goes to the requester that did not win last time; a lone requester always wins.
  always_comb begin
    any_valid  = bus.i_req0_valid | bus.i_req1_valid;
    grant      = (bus.i_req0_valid & bus.i_req1_valid) ? ~last_grant_q : bus.i_req1_valid;
    grant_fire = (state_q == S_IDLE) & any_valid & ~i_rst;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    a_d          = a_q;
    d_d          = d_q;
    n_d          = n_q;
    result_d     = result_q;
    jobs_d       = jobs_q;
    spurious_d   = spurious_q;

    case (state_q)
      S_IDLE: begin
        if (grant_fire) begin
          a_d          = grant ? bus.i_req1_a : bus.i_req0_a;
          d_d          = grant ? bus.i_req1_d : bus.i_req0_d;
          n_d          = grant ? bus.i_req1_n : bus.i_req0_n;
          id_d         = grant;
          last_grant_d = grant;
          state_d      = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Core result is only meaningful on the finished cycle itself.
        if (bus.i_core_finished) begin
          result_d = bus.i_core_result;
          state_d  = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.i_rsp_ready) begin
          jobs_d  = jobs_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (bus.i_core_finished && (state_q != S_WAIT)) begin
      spurious_d = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      a_q          <= '0;
      d_q          <= '0;
      n_q          <= '0;
      result_q     <= '0;
      jobs_q       <= '0;
      spurious_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      a_q          <= a_d;
      d_q          <= d_d;
      n_q          <= n_d;
      result_q     <= result_d;
      jobs_q       <= jobs_d;
      spurious_q   <= spurious_d;
    end
  end

  always_comb begin
    bus.o_req0_ready = grant_fire & ~grant;
    bus.o_req1_ready = grant_fire & grant;
    bus.o_core_start = (state_q == S_LAUNCH);
    bus.o_core_a     = a_q;
    bus.o_core_d     = d_q;
    bus.o_core_n     = n_q;
    bus.o_rsp_valid  = (state_q == S_RESP);
    bus.o_rsp_id     = id_q;
    bus.o_rsp_data   = result_q;
    bus.o_busy       = (state_q != S_IDLE);
    bus.o_jobs_done  = jobs_q;
    bus.o_spurious   = spurious_q;
  end

endmodule

// File: tb/tb_rsa_job_arbiter.sv
// Bench for rsa_job_arbiter: behavioural core (modexp or a+d, fixed latency) plus grant/response scoreboards.
module tb_rsa_job_arbiter;
  localparam int DATA_W = 256;
  localparam int CNT_W  = 16;
  localparam int W      = DATA_W;

  typedef logic [W-1:0] word_t;
  typedef struct packed {word_t a; word_t d; word_t n;} job_t;
  typedef struct packed {logic id; word_t data;} rsp_t;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;

  rsa_job_arbiter_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) ifc ();

  rsa_job_arbiter #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (ifc)
  );

  always #5 i_clk = ~i_clk;

  int    n_chk = 0;
  int    n_err = 0;
  int    n_done = 0;
  int    cyc = 0;
  int    grant_cyc = 0;
  int    core_lat = 5;
  int    core_cnt = 0;
  bit    core_mode = 1'b0;
  bit    spur_req = 1'b0;
  bit    auto_drv = 1'b1;
  logic  prev_start = 1'b0;
  logic  prev_rsp = 1'b0;
  word_t last_data = '0;

  job_t q0[$];
  job_t q1[$];
  rsp_t sb[$];
  logic exp_gnt[$];

  function automatic word_t modexp(word_t a, word_t d, word_t n);
    logic [2*W-1:0] r, b, m;
    if (n == '0) return '0;
    m = {{W{1'b0}}, n};
    r = 1;
    b = {{W{1'b0}}, a} % m;
    for (int i = 0; i < W; i++) begin
      if (d[i]) r = (r * b) % m;
      b = (b * b) % m;
    end
    return r[W-1:0];
  endfunction

  function automatic word_t model(job_t j);
    return core_mode ? (j.a + j.d) : modexp(j.a, j.d, j.n);
  endfunction

  task automatic chk(string tag, word_t obs, word_t exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Behavioural core: reads operands at the finish cycle, result reads 1 on every other cycle.
  initial begin
    ifc.i_core_finished = 1'b0;
    ifc.i_core_result   = W'(1);
    forever begin
      @(posedge i_clk);
      #2;
      ifc.i_core_finished = 1'b0;
      ifc.i_core_result   = W'(1);
      if (i_rst) begin
        core_cnt = 0;
      end else if (ifc.o_core_start) begin
        core_cnt = core_lat;
      end else if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          ifc.i_core_finished = 1'b1;
          ifc.i_core_result   = model('{ifc.o_core_a, ifc.o_core_d, ifc.o_core_n});
        end
      end
      if (spur_req) ifc.i_core_finished = 1'b1;
    end
  end

  task automatic monitor();
    job_t j;
    rsp_t e;
    logic id;
    logic eg;
    if (!i_rst && (ifc.o_req0_ready || ifc.o_req1_ready)) begin
      chk("rdy_excl", W'(ifc.o_req0_ready & ifc.o_req1_ready), W'(0));
      if (ifc.o_req0_ready) chk("rdy0_vld", W'(ifc.i_req0_valid), W'(1));
      if (ifc.o_req1_ready) chk("rdy1_vld", W'(ifc.i_req1_valid), W'(1));
    end
    if (!i_rst && ((ifc.i_req0_valid && ifc.o_req0_ready) || (ifc.i_req1_valid && ifc.o_req1_ready))) begin
      id = ifc.o_req1_ready;
      j  = id ? '{ifc.i_req1_a, ifc.i_req1_d, ifc.i_req1_n} : '{ifc.i_req0_a, ifc.i_req0_d, ifc.i_req0_n};
      chk("gnt_pending", W'(exp_gnt.size() > 0), W'(1));
      if (exp_gnt.size() > 0) begin
        eg = exp_gnt.pop_front();
        chk("gnt_id", W'(id), W'(eg));
      end
      sb.push_back('{id, model(j)});
      grant_cyc = cyc;
      if (id && q1.size() > 0) void'(q1.pop_front());
      if (!id && q0.size() > 0) void'(q0.pop_front());
    end
    if (ifc.o_core_start) begin
      chk("start_lat", W'(cyc - grant_cyc), W'(1));
      chk("start_pulse", W'(prev_start), W'(0));
    end
    if (ifc.o_rsp_valid && !prev_rsp) chk("rsp_lat", W'(cyc - grant_cyc), W'(core_lat + 2));
    if (!i_rst && ifc.o_rsp_valid && ifc.i_rsp_ready) begin
      chk("rsp_pending", W'(sb.size() > 0), W'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_id", W'(ifc.o_rsp_id), W'(e.id));
        chk("rsp_data", ifc.o_rsp_data, e.data);
      end
      last_data = ifc.o_rsp_data;
      n_done++;
    end
    prev_start = ifc.o_core_start;
    prev_rsp   = ifc.o_rsp_valid;
  endtask

  task automatic drive_reqs();
    ifc.i_req0_valid = (q0.size() > 0);
    ifc.i_req1_valid = (q1.size() > 0);
    {ifc.i_req0_a, ifc.i_req0_d, ifc.i_req0_n} = (q0.size() > 0) ? q0[0] : '0;
    {ifc.i_req1_a, ifc.i_req1_d, ifc.i_req1_n} = (q1.size() > 0) ? q1[0] : '0;
  endtask

  task automatic tick();
    @(negedge i_clk);
    monitor();
    @(posedge i_clk);
    cyc++;
    #1;
    if (auto_drv) drive_reqs();
  endtask

  task automatic ticks(int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic wait_done(int target, string tag);
    for (int k = 0; k < 400 && n_done < target; k++) tick();
    chk(tag, W'(n_done), W'(target));
  endtask

  task automatic do_reset();
    i_rst    = 1'b1;
    auto_drv = 1'b1;
    q0.delete();
    q1.delete();
    sb.delete();
    exp_gnt.delete();
    n_done = 0;
    tick();
    chk("rst_rdy0",   W'(ifc.o_req0_ready), W'(0));
    chk("rst_rdy1",   W'(ifc.o_req1_ready), W'(0));
    chk("rst_rspv",   W'(ifc.o_rsp_valid),  W'(0));
    chk("rst_rspid",  W'(ifc.o_rsp_id),     W'(0));
    chk("rst_rspd",   ifc.o_rsp_data,       W'(0));
    chk("rst_start",  W'(ifc.o_core_start), W'(0));
    chk("rst_a",      ifc.o_core_a,         W'(0));
    chk("rst_d",      ifc.o_core_d,         W'(0));
    chk("rst_n",      ifc.o_core_n,         W'(0));
    chk("rst_busy",   W'(ifc.o_busy),       W'(0));
    chk("rst_jobs",   W'(ifc.o_jobs_done),  W'(0));
    chk("rst_spur",   W'(ifc.o_spurious),   W'(0));
    i_rst = 1'b0;
  endtask

  initial begin
    ifc.i_req0_valid = 1'b0;
    ifc.i_req1_valid = 1'b0;
    ifc.i_req0_a = '0; ifc.i_req0_d = '0; ifc.i_req0_n = '0;
    ifc.i_req1_a = '0; ifc.i_req1_d = '0; ifc.i_req1_n = '0;
    ifc.i_rsp_ready = 1'b0;

    do_reset();

    // Single job through the modexp core: 4^13 mod 497 = 445.
    core_mode = 1'b0;
    core_lat  = 8;
    ifc.i_rsp_ready = 1'b1;
    exp_gnt.push_back(1'b0);
    q0.push_back('{W'(4), W'(13), W'(497)});
    wait_done(1, "single_done");
    chk("single_data", last_data, W'(445));
    tick();
    chk("single_jobs", W'(ifc.o_jobs_done), W'(1));

    // Simultaneous requests straight after reset: requester 0 first.
    do_reset();
    core_mode = 1'b1;
    core_lat  = 5;
    ifc.i_rsp_ready = 1'b1;
    exp_gnt.push_back(1'b0);
    exp_gnt.push_back(1'b1);
    q0.push_back('{W'(1), W'(2), W'(0)});
    q1.push_back('{W'(10), W'(20), W'(0)});
    wait_done(2, "simul_done");
    chk("simul_last", last_data, W'(30));
    tick();
    chk("simul_jobs", W'(ifc.o_jobs_done), W'(2));

    // Both requesters continuously valid: strict alternation.
    do_reset();
    ifc.i_rsp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      q0.push_back('{W'(100 + j), W'(7), W'(0)});
      q1.push_back('{W'(200 + j), W'(9), W'(0)});
      exp_gnt.push_back(1'b0);
      exp_gnt.push_back(1'b1);
    end
    wait_done(6, "fair_done");
    tick();
    chk("fair_jobs", W'(ifc.o_jobs_done), W'(6));

    // Response stall for 20 cycles while the other requester waits.
    ifc.i_rsp_ready = 1'b0;
    exp_gnt.push_back(1'b1);
    q1.push_back('{W'(40), W'(2), W'(0)});
    for (int k = 0; k < 50 && !ifc.o_rsp_valid; k++) tick();
    chk("bp_reach", W'(ifc.o_rsp_valid), W'(1));
    exp_gnt.push_back(1'b0);
    q0.push_back('{W'(50), W'(1), W'(0)});
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("bp_vld",   W'(ifc.o_rsp_valid), W'(1));
      chk("bp_id",    W'(ifc.o_rsp_id),    W'(1));
      chk("bp_data",  ifc.o_rsp_data,      W'(42));
      chk("bp_quiet", W'({ifc.o_req0_ready, ifc.o_req1_ready, ifc.o_core_start}), W'(0));
    end
    ifc.i_rsp_ready = 1'b1;
    tick();
    chk("bp_idle",    W'(ifc.o_busy),       W'(0));
    chk("bp_regrant", W'(ifc.o_req0_ready), W'(1));
    wait_done(8, "bp_done");
    tick();
    chk("bp_jobs", W'(ifc.o_jobs_done), W'(8));

    // Spurious finish in IDLE, then operand changes after the grant.
    spur_req = 1'b1;
    tick();
    spur_req = 1'b0;
    chk("spur_flag", W'(ifc.o_spurious), W'(1));
    ticks(3);
    chk("spur_sticky", W'(ifc.o_spurious), W'(1));
    chk("spur_idle",   W'({ifc.o_busy, ifc.o_rsp_valid}), W'(0));
    chk("spur_jobs",   W'(ifc.o_jobs_done), W'(8));
    auto_drv  = 1'b0;
    core_mode = 1'b0;
    core_lat  = 10;
    exp_gnt.push_back(1'b0);
    ifc.i_req0_valid = 1'b1;
    ifc.i_req0_a = W'(5); ifc.i_req0_d = W'(3); ifc.i_req0_n = W'(1000);
    for (int k = 0; k < 20 && !ifc.o_busy; k++) tick();
    ifc.i_req0_valid = 1'b0;
    ticks(3);
    ifc.i_req0_a = W'(9); ifc.i_req0_d = W'(2); ifc.i_req0_n = W'(7);
    tick();
    chk("stab_a", ifc.o_core_a, W'(5));
    chk("stab_d", ifc.o_core_d, W'(3));
    chk("stab_n", ifc.o_core_n, W'(1000));
    wait_done(9, "stab_done");
    chk("stab_data", last_data, W'(125));
    auto_drv = 1'b1;

    // Reset three cycles after start drops the job; next job from requester 1.
    core_mode = 1'b1;
    core_lat  = 20;
    exp_gnt.push_back(1'b0);
    q0.push_back('{W'(7), W'(7), W'(0)});
    for (int k = 0; k < 20 && !ifc.o_core_start; k++) tick();
    chk("rst_start_seen", W'(ifc.o_core_start), W'(1));
    ticks(3);
    do_reset();
    core_lat = 5;
    exp_gnt.push_back(1'b1);
    q1.push_back('{W'(3), W'(4), W'(0)});
    wait_done(1, "rst_next_done");
    chk("rst_next_data", last_data, W'(7));
    tick();
    chk("rst_next_jobs", W'(ifc.o_jobs_done), W'(1));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/rsa_job_arbiter.md
# rsa_job_arbiter

Two-requester job scheduler that shares a single Rsa256Core instance. It accepts modular-exponentiation jobs (a, d, n) from two independent clients over valid/ready handshakes and grants them round-robin. It latches each job's operands and holds them stable while the core runs. It issues the core's single-cycle start pulse, captures the result on the core's finished pulse, and returns it with the requester ID on one shared response channel.

## Interface
- DATA_W, 256, operand/result width; must match the core.
- CNT_W, 16, width of the completed-job counter.

- i_clk  in  1  clock.
- i_rst  in  1  reset; synchronous, active-high; clock i_clk.
- i_req0_valid  in  1  requester 0 has a job.
- o_req0_ready  out  1  requester 0 job accepted this cycle.
- i_req0_a / i_req0_d / i_req0_n  in  DATA_W each  requester 0 base, exponent, modulus.
- i_req1_valid, o_req1_ready, i_req1_a / i_req1_d / i_req1_n  same for requester 1.
- o_rsp_valid  out  1  result available.
- i_rsp_ready  in  1  downstream accepts result.
- o_rsp_id  out  1  requester that owns the result.
- o_rsp_data  out  DATA_W  a^d mod n.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a / o_core_d / o_core_n  out  DATA_W each  latched operands to the core.
- i_core_result  in  DATA_W  core o_a_pow_d.
- i_core_finished  in  1  core o_finished (one-cycle pulse).
- o_busy  out  1  high in every state except IDLE.
- o_jobs_done  out  CNT_W  completed responses; wraps modulo 2^CNT_W.
- o_spurious  out  1  sticky flag; set when i_core_finished arrives outside WAIT.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- **IDLE**
  - Grant g is chosen combinationally from the valid inputs.
  - If only one requester is valid, that requester wins.
  - If both are valid, the requester other than last_grant wins.
  - o_req{g}_ready = 1 only for the winner, only in IDLE. The other ready stays 0.
  - On grant: latch a/d/n into the operand registers, store id = g, set last_grant = g, go to LAUNCH.
  - If nothing is valid, stay in IDLE.
- **LAUNCH**: o_core_start = 1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - On i_core_finished: capture i_core_result into the result register in that same cycle, then go to RESP.
  - The core's output is only valid on the finished cycle; it reverts to 1 on the next cycle.
- **RESP**
  - o_rsp_valid = 1; o_rsp_id and o_rsp_data come from registers.
  - On i_rsp_ready: o_jobs_done += 1, go to IDLE.
  - Without i_rsp_ready: hold valid, id and data unchanged indefinitely.
- **Operand stability**: o_core_a/d/n are driven from the operand registers. They change only on an IDLE grant, so they stay stable through LAUNCH, WAIT and RESP. The core reads d and n during the whole computation.
- **Core start rule**: o_core_start is never asserted outside LAUNCH. A single job is therefore never restarted mid-computation.
- **Spurious finish**: i_core_finished in IDLE, LAUNCH or RESP is ignored for data and state, and sets o_spurious. o_spurious clears only on reset.
- **Requester inputs**: operand inputs are sampled only at the grant cycle. Changes after the grant have no effect.

## Timing
- **Reset values**: state IDLE, last_grant = 1 (requester 0 wins the first tie). All outputs 0: o_req*_ready, o_rsp_valid, o_rsp_id, o_rsp_data, o_core_start, o_core_a/d/n, o_busy, o_jobs_done, o_spurious.
- **Per-job timeline**, with the grant in IDLE at cycle T:
  - o_core_start high at T+1.
  - Core finish at T+1+L (L = core latency).
  - o_rsp_valid high from T+2+L.
- Arbiter overhead: 3 cycles per job beyond L, plus any response stall.
- **Back-to-back**: after the response handshake at cycle R, IDLE at R+1 and the next grant can occur at R+1. Throughput is one job per L+3 cycles minimum.
- **Simultaneous requests at reset**: requester 0 is served first and requester 1 next. Under continuous requests from both sides, grants strictly alternate.
- **Reset mid-operation**: the FSM returns to IDLE next cycle and all outputs follow the reset values. The pending job is dropped with no response. The core is reset by the same i_rst.

## Test plan
- **Single job, real core**: req0 a=4, d=13, n=497 → o_req0_ready one cycle; o_core_start one cycle later; o_rsp_valid with id=0, data=445; o_jobs_done=1.
- **Simultaneous requests after reset, stub core** (fixed L=5, result=a+d): req0 (a=1,d=2) and req1 (a=10,d=20) both held valid → response 3 with id=0 first, then 30 with id=1. Grant-to-response = 7 cycles each.
- **Fairness**: both requesters continuously valid for 6 jobs → grant id sequence 0,1,0,1,0,1. o_jobs_done=6.
- **Backpressure**: hold i_rsp_ready=0 for 20 cycles in RESP → o_rsp_valid, o_rsp_id and o_rsp_data unchanged. No new ready or start issued. Release → back to IDLE next cycle.
- **Spurious finish**: pulse i_core_finished in IDLE → o_spurious=1, no response, state IDLE. Also change i_req0_n after grant in WAIT → o_core_n unchanged.
- **Reset mid-WAIT**: assert i_rst 3 cycles after start → all outputs 0 next cycle. The subsequent req1 job completes normally with id=1.
